// File: rtl/pipeline_types.sv
// Pipeline-register payloads passed between the EX, MEM and WB stages.
package pipeline_types;

    import rv32_isa::*;

    localparam int unsigned RegAddrWidth = 5;

    typedef struct packed {
        logic [Func3Width-1:0] func3;
        logic                  mem_read;
        logic                  mem_write;
        logic                  reg_write;
    } ctrl_t;

    typedef struct packed {
        logic [RegAddrWidth-1:0] addr;
        logic [RegWidth-1:0]     value;
    } reg_t;

    typedef struct packed {
        ctrl_t ctrl;
        reg_t  rs;
        reg_t  rd;
    } ex_mem_t;

    typedef struct packed {
        ctrl_t ctrl;
        reg_t  rd;
    } mem_wb_t;

endpackage

// File: rtl/rv32_isa.sv
// RV32 ISA constants shared by the pipeline: register width and load/store func3 encodings.
package rv32_isa;

    localparam int unsigned RegWidth   = 32;
    localparam int unsigned Func3Width = 3;

    localparam logic [Func3Width-1:0] Func3Byte  = 3'b000;
    localparam logic [Func3Width-1:0] Func3Half  = 3'b001;
    localparam logic [Func3Width-1:0] Func3Word  = 3'b010;
    localparam logic [Func3Width-1:0] Func3ByteU = 3'b100;
    localparam logic [Func3Width-1:0] Func3HalfU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half/word out of a read bus word and sign- or zero-extends it.
module load_align
    import rv32_isa::*;
(
    input  logic [31:0]           iData,
    input  logic [1:0]            iOffset,
    input  logic [Func3Width-1:0] iFunc3,
    output logic [RegWidth-1:0]   oValue
);

    logic [31:0] shifted;

    assign shifted = iData >> {iOffset, 3'b000};

    always_comb begin
        oValue = '0;
        case (iFunc3)
            Func3Byte:  oValue = RegWidth'({{24{shifted[7]}}, shifted[7:0]});
            Func3Half:  oValue = RegWidth'({{16{shifted[15]}}, shifted[15:0]});
            Func3ByteU: oValue = RegWidth'({24'h0, shifted[7:0]});
            Func3HalfU: oValue = RegWidth'({16'h0, shifted[15:0]});
            default:    oValue = RegWidth'(shifted);
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: issues data-memory requests, stalls upstream while waiting,
// aligns load data and registers the writeback record.
module mem_access
    import rv32_isa::*;
    import pipeline_types::*;
(
    input  logic                iClk,
    input  logic                nRst,
    input  logic                iStall,
    input  ex_mem_t             iEX,
    output mem_wb_t             oWB,
    output logic [RegWidth-1:0] oFwMe,
    output logic                oStall,
    output logic                oMisalign,
    output logic                oDmReq,
    output logic                oDmWe,
    output logic [31:0]         oDmAddr,
    output logic [31:0]         oDmWData,
    output logic [3:0]          oDmBe,
    input  logic                iDmAck,
    input  logic [31:0]         iDmRData
);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t              state;
    mem_wb_t             pend;
    mem_wb_t             holdWb;
    mem_wb_t             idleWb;
    mem_wb_t             wbResult;
    logic [RegWidth-1:0] loadValue;
    logic [1:0]          offset;
    logic                memOp;
    logic                misaligned;
    logic                issue;
    logic [3:0]          laneBe;
    logic [31:0]         laneData;
    logic                unusedRsAddr;

    assign unusedRsAddr = ^iEX.rs.addr;

    assign offset = iEX.rd.value[1:0];
    assign memOp  = iEX.ctrl.mem_read | iEX.ctrl.mem_write;
    assign issue  = memOp & ~misaligned;
    assign oFwMe  = oWB.rd.value;
    assign oStall = nRst & (((state == IDLE) & issue) | (state == WAIT));

    // func3[1:0] gives the access size; bit 2 only selects zero-extension
    always_comb begin
        misaligned = 1'b0;
        laneBe     = 4'b1111;
        laneData   = iEX.rs.value[31:0];
        case (iEX.ctrl.func3[1:0])
            2'b00: begin
                laneBe   = 4'b0001 << offset;
                laneData = {4{iEX.rs.value[7:0]}};
            end
            2'b01: begin
                misaligned = offset[0];
                laneBe     = 4'b0011 << offset;
                laneData   = {2{iEX.rs.value[15:0]}};
            end
            default: misaligned = (offset != 2'b00);
        endcase
    end

    // A misaligned op still retires, but must not write the register file
    always_comb begin
        idleWb.ctrl = iEX.ctrl;
        idleWb.rd   = iEX.rd;
        if (memOp && misaligned) begin
            idleWb.ctrl.reg_write = 1'b0;
        end
    end

    always_comb begin
        wbResult = pend;
        if (pend.ctrl.mem_read) begin
            wbResult.rd.value = loadValue;
        end
    end

    load_align uLoadAlign (
        .iData   (iDmRData),
        .iOffset (pend.rd.value[1:0]),
        .iFunc3  (pend.ctrl.func3),
        .oValue  (loadValue)
    );

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state     <= IDLE;
            oWB       <= '0;
            holdWb    <= '0;
            pend      <= '0;
            oMisalign <= 1'b0;
            oDmReq    <= 1'b0;
            oDmWe     <= 1'b0;
            oDmAddr   <= '0;
            oDmWData  <= '0;
            oDmBe     <= '0;
        end else begin
            oMisalign <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue) begin
                        oDmReq      <= 1'b1;
                        oDmWe       <= iEX.ctrl.mem_write;
                        oDmAddr     <= {iEX.rd.value[31:2], 2'b00};
                        oDmWData    <= iEX.ctrl.mem_write ? laneData : 32'h0;
                        oDmBe       <= laneBe;
                        pend.ctrl   <= iEX.ctrl;
                        pend.rd     <= iEX.rd;
                        if (!iStall) begin
                            oWB <= '0;
                        end
                        state <= WAIT;
                    end else if (!iStall) begin
                        oWB       <= idleWb;
                        oMisalign <= memOp & misaligned;
                    end
                end
                WAIT: begin
                    if (iDmAck) begin
                        oDmReq <= 1'b0;
                        oDmWe  <= 1'b0;
                        if (!iStall) begin
                            oWB   <= wbResult;
                            state <= IDLE;
                        end else begin
                            holdWb <= wbResult;
                            state  <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!iStall) begin
                        oWB   <= holdWb;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
